turbo_block_encoder: RTL
========================

# turbo_block_encoder

Parametrised rate-1/3 / rate-1/2 turbo encoder that accepts data bytes over a valid/ready handshake, assembles K-bit blocks in a ping-pong buffer, and interleaves with a generalised row-column permutation. Two terminated RSC constituents (g = 7/5 octal) encode each block, and the block drives a backpressured serial bit stream with block framing. It supersedes the fixed 8-bit serial encoder path and sits between the byte source and the channel/modulator stage.

## Interface
- `K`, 8: block length in bits; power of 2, 8..256; multiple of 8.
- `INTLV_ROWS`, 2: interleaver rows R; power of 2 dividing K; columns C = K/R.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous and active-low.
- `in_data`  in  8  input byte; bit b of byte n is block bit 8n+b.
- `in_valid`  in  1  byte offered.
- `in_ready`  out  1  byte accepted when `in_valid & in_ready`.
- `rate_half`  in  1  puncture mode; sampled when a block starts encoding.
- `out_bit`  out  1  coded bit.
- `out_valid`  out  1  `out_bit` valid.
- `out_ready`  in  1  sink takes the bit when `out_valid & out_ready`.
- `out_first`  out  1  first bit of a coded block (qualified by `out_valid`).
- `out_last`  out  1  last bit of a coded block.
- `busy`  out  1  any buffer full or encoding in progress.

## Operation
- **Input buffers.** Two K-bit buffers, A and B. The fill pointer counts bytes 0..K/8-1. On the last byte the buffer is marked full and filling moves to the other buffer. `in_ready` = 1 while the current fill buffer is not full.
- **Interleaver.** u'(i) = u(π(i)), with π(i) = (i mod R)·C + i div R. For K=8, R=2 this gives 0,4,1,5,2,6,3,7.
- **RSC step.** State (s1,s2). a = d^s1^s2; p = a^s2; next state (a, s1). Both encoders reset to 00 at block start.
- **Encoder FSM.** States IDLE → DATA → TAIL1 → TAIL2 → IDLE.
  - IDLE: when a full buffer exists (A first after reset, then alternating), latch `rate_half`, assert `out_first` on the next bit, enter DATA.
  - DATA: steps i = 0..K-1.
    - Rate 1/3 emits sys u(i), p1, p2.
    - Rate 1/2 emits u(i), p1 for even i, and u(i), p2 for odd i.
  - TAIL1: 2 steps of encoder 1 only, with d = s1^s2. Each step emits d, p1.
  - TAIL2: 2 steps of encoder 2 only, emitting d, p2. Tail bits are never punctured.
  - Return to IDLE: after the last tail bit is accepted. The buffer is freed on the same cycle, and the next full buffer starts immediately with no idle cycle.
- **Block length.** Rate 1/3 produces 3K+8 bits per block; rate 1/2 produces 2K+8.
- **Serialiser.** 3-bit holding register plus a count. An encoder step occurs only when the register is empty, or is being emptied by its final accepted bit on that cycle.
- **Outputs.** `out_last` marks the final TAIL2 bit. `out_bit` is held stable while `out_valid & ~out_ready`.
- **Mid-block inputs.** `rate_half` changes during a block have no effect.
- **Reset.** `rst` = 0 on any cycle clears both buffers, the FSM (to IDLE), the encoder states and the serialiser. The partial block is discarded.
- **Reset values.** `in_ready` = 0 during reset and 1 on the first cycle after. `out_valid`, `out_first`, `out_last`, `busy`, `out_bit` are all 0.

## Timing
- **Start latency.** Last byte accepted at edge T with the encoder idle: first coded bit has `out_valid` = 1 after edge T+1.
- **Throughput.** 1 coded bit/cycle with `out_ready` held high. Encoder steps every 3 cycles (rate 1/3) or 2 cycles (rate 1/2).
- **Input.** One byte per cycle while `in_ready` is high. A full block loads in K/8 cycles.
- **Both buffers full.** `in_ready` drops on the cycle after the second buffer completes. It rises on the cycle after the encoding buffer is freed.
- **Simultaneous events.** Freeing a buffer and filling the other buffer's last byte on the same edge is legal. The new block starts on the next edge.

## Structure
- **Shared package `turbo_pkg`:**
  - generator constants `G_FB = 3'o7`, `G_FF = 3'o5`
  - `TAIL_STEPS = 2`
  - FSM state enum
  - a `pi_index(i, R, C)` function, also used by the reference model
- **Sub-module `rsc_term_core`:** one constituent with `clk`, `rst`, `clear`, `step`, `terminate`, `d`, `sys_out`, `par_out`. Instantiated twice.

## Test plan
- **All-zero block.** K=8, byte 0x00, rate 1/3, `out_ready` = 1 → 32 bits, all 0. `out_first` on bit 0, `out_last` on bit 31, `out_valid` 1 cycle after byte accepted.
- **Impulse, rate 1/3.** Byte 0x01, rate 1/3.
  - DATA triples: sys 1,0,0,0,0,0,0,0; p1 = p2 = 1,1,1,0,1,1,0,1.
  - TAIL1 bits: 0,1,1,1. TAIL2 bits: 0,1,1,1.
- **Interleaver.** Byte 0x02 → sys 1 only at step 1; p2 first 1 at step 2; p1 first 1 at step 1. Checked against the model with π = 0,4,1,5,2,6,3,7.
- **Puncturing.** Byte 0x01 with `rate_half` = 1 → 24 bits; first six bits 1,1,0,1,0,1. Toggling `rate_half` mid-block changes nothing.
- **Backpressure and ping-pong.** Three back-to-back blocks with random `out_ready` (50%) → `in_ready` low while both buffers are full, stream bit-exact to the model, `out_bit` stable under stall, no gap between blocks when `out_ready` = 1.
- **Reset mid-block.** `rst` = 0 at DATA step 3 → next cycle `out_valid` = 0, `in_ready` = 0. After release, a fresh 0x01 block reproduces the impulse stream exactly.

Source files
------------

// File: rtl/turbo_block_encoder_pkg.sv
// Shared constants, encoder FSM states and the row-column
// interleaver index, used by the RTL and by reference models.
package turbo_pkg;

  localparam logic [2:0] G_FB = 3'o7;
  localparam logic [2:0] G_FF = 3'o5;
  localparam int TAIL_STEPS = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_TAIL1,
    S_TAIL2
  } enc_state_e;

  function automatic int pi_index(int i, int r, int c);
    return (i % r) * c + i / r;
  endfunction

endpackage

// File: rtl/turbo_block_encoder_if.sv
// Byte input and coded-bit output handshakes of the
// turbo block encoder.
interface turbo_block_encoder_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       out_bit;
  logic       out_valid;
  logic       out_ready;
  logic       out_first;
  logic       out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_bit, out_valid,
    input  out_first, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_bit, out_valid,
    output out_first, out_last
  );

endinterface

// File: rtl/turbo_block_encoder_rsc.sv
// One recursive systematic constituent (7/5) with
// trellis termination driven by its own feedback.
module rsc_term_core
  import turbo_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic step,
  input  logic terminate,
  input  logic d,
  output logic sys_out,
  output logic par_out
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic fb, a;

  always_comb begin
    fb = (G_FB[1] & s1_q) ^ (G_FB[0] & s2_q);
    // terminating input cancels the feedback, forcing a = 0
    sys_out = terminate ? fb : d;
    a = sys_out ^ fb;
    par_out = (G_FF[2] & a)
            ^ (G_FF[1] & s1_q)
            ^ (G_FF[0] & s2_q);
    s1_d = s1_q;
    s2_d = s2_q;
    if (clear) begin
      s1_d = 1'b0;
      s2_d = 1'b0;
    end else if (step) begin
      s1_d = a;
      s2_d = s1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

endmodule

// File: rtl/turbo_block_encoder.sv
// Ping-pong block buffer, row-column interleaver, two
// terminated RSC constituents and a 3-bit serialiser.
module turbo_block_encoder
  import turbo_pkg::*;
#(
  parameter int K          = 8,
  parameter int INTLV_ROWS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rate_half,
  output logic busy,
  turbo_block_encoder_if.slave bus
);

  localparam int C  = K / INTLV_ROWS;
  localparam int NB = K / 8;
  localparam int IW = $clog2(K);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  enc_state_e        state_q, state_d;
  logic [1:0][K-1:0] buf_q, buf_d;
  logic [1:0]        full_q, full_d;
  logic              fill_sel_q, fill_sel_d;
  logic              enc_sel_q, enc_sel_d;
  logic [BW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [IW-1:0]     step_q, step_d;
  logic              rate_q, rate_d;
  logic [2:0]        sr_q, sr_d;
  logic [2:0]        fm_q, fm_d;
  logic [2:0]        lm_q, lm_d;
  logic [1:0]        cnt_q, cnt_d;

  logic          in_ready, out_valid;
  logic          accept, pop, can_load;
  logic          done, start, blk_sel;
  logic          step_dat, step_t1, step_t2;
  logic          rate_eff, clr;
  logic [IW-1:0] idx, pidx;
  logic          u_sys, u_int;
  logic          sys1, par1, sys2, par2;

  assign in_ready      = rst & ~full_q[fill_sel_q];
  assign out_valid     = (cnt_q != 2'd0);
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_bit   = sr_q[0];
  assign bus.out_first = fm_q[0] & out_valid;
  assign bus.out_last  = lm_q[0] & out_valid;
  assign busy = (|full_q) | (state_q != S_IDLE);

  always_comb begin
    accept   = bus.in_valid & in_ready;
    pop      = out_valid & bus.out_ready;
    can_load = (cnt_q == 2'd0)
             | ((cnt_q == 2'd1) & bus.out_ready);
    done = (state_q == S_TAIL2)
         & (step_q == IW'(TAIL_STEPS))
         & pop & lm_q[0];
    // the next block starts on the same edge its predecessor drains
    blk_sel = done ? ~enc_sel_q : enc_sel_q;
    start = ((state_q == S_IDLE) | done)
          & full_q[blk_sel] & can_load;
    step_dat = start
             | ((state_q == S_DATA) & can_load);
    step_t1 = (state_q == S_TAIL1) & can_load;
    step_t2 = (state_q == S_TAIL2)
            & (step_q < IW'(TAIL_STEPS)) & can_load;
    rate_eff = start ? rate_half : rate_q;
    idx   = start ? '0 : step_q;
    pidx  = IW'(pi_index(int'(idx), INTLV_ROWS, C));
    u_sys = buf_q[blk_sel][idx];
    u_int = buf_q[blk_sel][pidx];
    clr   = (state_q == S_IDLE) & ~start;
  end

  rsc_term_core u_enc1 (
    .clk       (clk),
    .rst       (rst),
    .clear     (clr),
    .step      (step_dat | step_t1),
    .terminate (step_t1),
    .d         (u_sys),
    .sys_out   (sys1),
    .par_out   (par1)
  );

  rsc_term_core u_enc2 (
    .clk       (clk),
    .rst       (rst),
    .clear     (clr),
    .step      (step_dat | step_t2),
    .terminate (step_t2),
    .d         (u_int),
    .sys_out   (sys2),
    .par_out   (par2)
  );

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    rate_d    = rate_q;
    enc_sel_d = blk_sel;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DATA;
          step_d  = IW'(1);
          rate_d  = rate_half;
        end
      end
      S_DATA: begin
        if (step_dat) begin
          if (step_q == IW'(K - 1)) begin
            state_d = S_TAIL1;
            step_d  = '0;
          end else begin
            step_d = step_q + IW'(1);
          end
        end
      end
      S_TAIL1: begin
        if (step_t1) begin
          if (step_q == IW'(TAIL_STEPS - 1)) begin
            state_d = S_TAIL2;
            step_d  = '0;
          end else begin
            step_d = step_q + IW'(1);
          end
        end
      end
      S_TAIL2: begin
        if (step_t2) begin
          step_d = step_q + IW'(1);
        end else if (done) begin
          if (start) begin
            state_d = S_DATA;
            step_d  = IW'(1);
            rate_d  = rate_half;
          end else begin
            state_d = S_IDLE;
            step_d  = '0;
          end
        end
      end
      default: ;
    endcase

    buf_d      = buf_q;
    full_d     = full_q;
    fill_sel_d = fill_sel_q;
    byte_cnt_d = byte_cnt_q;
    if (accept) begin
      for (int n = 0; n < NB; n++) begin
        if (byte_cnt_q == BW'(n))
          buf_d[fill_sel_q][8*n +: 8] = bus.in_data;
      end
      if (byte_cnt_q == BW'(NB - 1)) begin
        full_d[fill_sel_q] = 1'b1;
        fill_sel_d = ~fill_sel_q;
        byte_cnt_d = '0;
      end else begin
        byte_cnt_d = byte_cnt_q + BW'(1);
      end
    end
    if (done)
      full_d[enc_sel_q] = 1'b0;

    sr_d  = sr_q;
    fm_d  = fm_q;
    lm_d  = lm_q;
    cnt_d = cnt_q;
    if (pop) begin
      sr_d  = sr_q >> 1;
      fm_d  = fm_q >> 1;
      lm_d  = lm_q >> 1;
      cnt_d = cnt_q - 2'd1;
    end
    unique case (1'b1)
      step_dat: begin
        fm_d = {2'b00, start};
        lm_d = '0;
        if (!rate_eff) begin
          sr_d  = {par2, par1, sys1};
          cnt_d = 2'd3;
        end else begin
          sr_d  = {1'b0, idx[0] ? par2 : par1, sys1};
          cnt_d = 2'd2;
        end
      end
      step_t1: begin
        sr_d  = {1'b0, par1, sys1};
        cnt_d = 2'd2;
        fm_d  = '0;
        lm_d  = '0;
      end
      step_t2: begin
        sr_d  = {1'b0, par2, sys2};
        cnt_d = 2'd2;
        fm_d  = '0;
        lm_d  = (step_q == IW'(TAIL_STEPS - 1))
              ? 3'b010 : 3'b000;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      buf_q      <= '0;
      full_q     <= '0;
      fill_sel_q <= 1'b0;
      enc_sel_q  <= 1'b0;
      byte_cnt_q <= '0;
      step_q     <= '0;
      rate_q     <= 1'b0;
      sr_q       <= '0;
      fm_q       <= '0;
      lm_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      full_q     <= full_d;
      fill_sel_q <= fill_sel_d;
      enc_sel_q  <= enc_sel_d;
      byte_cnt_q <= byte_cnt_d;
      step_q     <= step_d;
      rate_q     <= rate_d;
      sr_q       <= sr_d;
      fm_q       <= fm_d;
      lm_q       <= lm_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
